// File: rtl/nco_sweep_ctrl_pkg.sv
// Shared types and defaults for the NCO sweep controller.
// Mode and state encodings plus the frequency word width.
package nco_pkg;

  localparam int STEP_SIZE_DEF = 16;
  localparam int DWELL_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_SAW    = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } state_e;

  // The reserved encoding behaves as a single sweep.
  function automatic mode_e norm_mode(
    input logic [1:0] m
  );
    if (m == 2'b11) return MODE_SINGLE;
    return mode_e'(m);
  endfunction

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Control/status bundle between a sweep requester and the controller.
// master drives the request side, slave is the controller.
interface nco_sweep_ctrl_if
  import nco_pkg::*;
#(
  parameter int STEP_SIZE   = STEP_SIZE_DEF,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
);

  logic                   start;
  logic                   abort;
  logic [1:0]             mode;
  logic [STEP_SIZE-1:0]   f_start;
  logic [STEP_SIZE-1:0]   f_stop;
  logic [STEP_SIZE-1:0]   f_inc;
  logic [DWELL_WIDTH-1:0] dwell;
  logic [STEP_SIZE-1:0]   step;
  logic                   busy;
  logic                   done;
  logic                   wrap;
  logic                   err;

  modport master (
    output start, abort, mode,
    output f_start, f_stop, f_inc, dwell,
    input  step, busy, done, wrap, err
  );

  modport slave (
    input  start, abort, mode,
    input  f_start, f_stop, f_inc, dwell,
    output step, busy, done, wrap, err
  );

endinterface

// File: rtl/nco_sweep_ctrl_sweep_dwell_cnt.sv
// Dwell counter: counts 0..dwell while enabled, then rolls over.
// tc marks the last cycle of a dwell period.
module sweep_dwell_cnt #(
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic                   tc
);

  logic [DWELL_WIDTH-1:0] cnt_q;

  assign tc = en && (cnt_q == dwell);

  // Count while enabled, roll over at terminal count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (tc) cnt_q <= '0;
      else    cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Linear chirp generator feeding the NCO frequency word.
// Single, sawtooth and triangle sweeps with dwell per step.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int STEP_SIZE   = STEP_SIZE_DEF,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  nco_sweep_ctrl_if.slave bus
);

  state_e state_q, state_d;
  mode_e  mode_q;

  logic [STEP_SIZE-1:0]   fstart_q;
  logic [STEP_SIZE-1:0]   fstop_q;
  logic [STEP_SIZE-1:0]   finc_q;
  logic [DWELL_WIDTH-1:0] dwell_q;

  logic [STEP_SIZE-1:0] step_q, step_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic wrap_q, wrap_d;
  logic err_q, err_d;
  logic load;
  logic tc;
  logic cnt_clr;
  logic cnt_en;

  logic [STEP_SIZE:0]   sum;
  logic [STEP_SIZE-1:0] diff;
  logic                 cfg_ok;

  assign sum    = {1'b0, step_q} + {1'b0, finc_q};
  assign diff   = step_q - finc_q;
  assign cfg_ok = bus.f_stop >= bus.f_start;

  assign cnt_clr = bus.abort || (state_q == IDLE);
  assign cnt_en  = (state_q != IDLE);

  sweep_dwell_cnt #(
    .DWELL_WIDTH(DWELL_WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .dwell(dwell_q),
    .tc   (tc)
  );

  assign bus.step = step_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;

  // Next state, next step word and status pulses.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      step_d  = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (cfg_ok) begin
              load    = 1'b1;
              step_d  = bus.f_start;
              busy_d  = 1'b1;
              state_d = UP;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        UP: begin
          if (tc) begin
            if (step_q == fstop_q) begin
              unique case (1'b1)
                mode_q == MODE_SAW: begin
                  step_d = fstart_q;
                  wrap_d = 1'b1;
                end
                mode_q == MODE_TRI: begin
                  wrap_d  = 1'b1;
                  state_d = DOWN;
                end
                default: begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
                end
              endcase
            end else if (sum >= {1'b0, fstop_q}) begin
              step_d = fstop_q;
            end else begin
              step_d = sum[STEP_SIZE-1:0];
            end
          end
        end
        DOWN: begin
          if (tc) begin
            if (step_q == fstart_q) begin
              wrap_d  = 1'b1;
              state_d = UP;
            end else if (finc_q > step_q ||
                         diff <= fstart_q) begin
              step_d = fstart_q;
            end else begin
              step_d = diff;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, step word and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  // Sweep configuration, captured only on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_SINGLE;
      fstart_q <= '0;
      fstop_q  <= '0;
      finc_q   <= '0;
      dwell_q  <= '0;
    end else if (load) begin
      mode_q   <= norm_mode(bus.mode);
      fstart_q <= bus.f_start;
      fstop_q  <= bus.f_stop;
      finc_q   <= bus.f_inc;
      dwell_q  <= bus.dwell;
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed vector bench for the NCO sweep controller.
// Per-cycle table plus a hand-written async reset sequence.
module tb_nco_sweep_ctrl;

  typedef struct {
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [15:0] fs;
    logic [15:0] fe;
    logic [15:0] fi;
    logic [15:0] dw;
    logic [15:0] st;
    logic        b;
    logic        d;
    logic        w;
    logic        e;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  vec_t vecs[$];

  nco_sweep_ctrl_if bus ();

  nco_sweep_ctrl dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic s, input logic a, input logic [1:0] m,
    input logic [15:0] fs, input logic [15:0] fe,
    input logic [15:0] fi, input logic [15:0] dw,
    input logic [15:0] st, input logic b,
    input logic d, input logic w, input logic e
  );
    vec_t v;
    v.start = s;  v.abort = a; v.mode = m;
    v.fs = fs;    v.fe = fe;   v.fi = fi; v.dw = dw;
    v.st = st;    v.b = b;     v.d = d;
    v.w = w;      v.e = e;
    return v;
  endfunction

  task automatic go(
    input logic [1:0] m, input logic [15:0] fs,
    input logic [15:0] fe, input logic [15:0] fi,
    input logic [15:0] dw, input logic [15:0] st,
    input logic b, input logic e
  );
    vecs.push_back(mk(1, 0, m, fs, fe, fi, dw, st, b, 0, 0, e));
  endtask

  task automatic ex(
    input logic [15:0] st, input logic b,
    input logic d, input logic w
  );
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, st, b, d, w, 0));
  endtask

  task automatic ex_n(input logic [15:0] st, input int n);
    for (int i = 0; i < n; i++) ex(st, 1, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string nm, input logic [15:0] st,
    input logic b, input logic d,
    input logic w, input logic e
  );
    n_cmp++;
    if ({bus.step, bus.busy, bus.done, bus.wrap, bus.err}
        !== {st, b, d, w, e}) begin
      n_bad++;
      $display("FAIL %s: got step=%0d busy=%b done=%b wrap=%b err=%b, want step=%0d busy=%b done=%b wrap=%b err=%b",
               nm, bus.step, bus.busy, bus.done, bus.wrap, bus.err,
               st, b, d, w, e);
    end
  endtask

  task automatic drive(
    input logic s, input logic a, input logic [1:0] m,
    input logic [15:0] fs, input logic [15:0] fe,
    input logic [15:0] fi, input logic [15:0] dw
  );
    bus.start = s; bus.abort = a; bus.mode = m;
    bus.f_start = fs; bus.f_stop = fe;
    bus.f_inc = fi; bus.dwell = dw;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // single sweep 100..130 step 10, dwell 2
    go(0, 100, 130, 10, 2, 100, 1, 0);
    ex_n(100, 2);
    ex_n(110, 3);
    ex_n(120, 3);
    ex_n(130, 3);
    ex(130, 0, 1, 0);
    ex(130, 0, 0, 0);

    // clamp to f_stop
    go(0, 100, 130, 12, 0, 100, 1, 0);
    ex(112, 1, 0, 0);
    ex(124, 1, 0, 0);
    ex(130, 1, 0, 0);
    ex(130, 0, 1, 0);
    ex(130, 0, 0, 0);

    // overflow clamp
    go(0, 16'hFFF0, 16'hFFFF, 16'h0020, 0, 16'hFFF0, 1, 0);
    ex(16'hFFFF, 1, 0, 0);
    ex(16'hFFFF, 0, 1, 0);
    ex(16'hFFFF, 0, 0, 0);

    // triangle 10..30, then abort
    go(2, 10, 30, 10, 0, 10, 1, 0);
    ex(20, 1, 0, 0);
    ex(30, 1, 0, 0);
    ex(30, 1, 0, 1);
    ex(20, 1, 0, 0);
    ex(10, 1, 0, 0);
    ex(10, 1, 0, 1);
    ex(20, 1, 0, 0);
    ex(30, 1, 0, 0);
    ex(30, 1, 0, 1);
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // f_start==f_stop with reserved mode 11, dwell 1
    go(3, 50, 50, 5, 1, 50, 1, 0);
    ex(50, 1, 0, 0);
    ex(50, 0, 1, 0);
    go(0, 9, 5, 1, 0, 50, 0, 1);
    ex(50, 0, 0, 0);

    // sawtooth, ignored start while busy, abort+start, err
    go(1, 0, 20, 10, 0, 0, 1, 0);
    ex(10, 1, 0, 0);
    ex(20, 1, 0, 0);
    go(0, 100, 200, 1, 5, 0, 1, 0);
    vecs[$].w = 1'b1;
    ex(10, 1, 0, 0);
    vecs.push_back(mk(1, 1, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0));
    ex(0, 0, 0, 0);
    go(0, 9, 5, 1, 0, 0, 0, 1);
    ex(0, 0, 0, 0);

    // f_inc==0 holds f_start until abort
    go(0, 40, 60, 0, 0, 40, 1, 0);
    ex_n(40, 10);
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    check("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].abort, vecs[i].mode,
            vecs[i].fs, vecs[i].fe, vecs[i].fi, vecs[i].dw);
      tick();
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].b,
            vecs[i].d, vecs[i].w, vecs[i].e);
    end

    // async reset mid-sweep
    drive(1, 0, 0, 1000, 2000, 100, 3);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    check("mid_sweep", 1100, 1, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_reset%0d", i), 0, 0, 0, 0, 0);
    end
    drive(1, 0, 0, 1000, 2000, 100, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("restart", 1000, 1, 0, 0, 0);
    tick();
    check("restart_adv", 1100, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
